alu_issue_stage: RTL and testbench

//  ID/EX issue stage on the producer side of the ALU interface. Accepts a decoded-register-read
//  RV32I instruction, generates the 6-bit ALU control code, selects and extends the second operand
//  (register or immediate) and registers Read_data1/Mux_Data/ALU_Control for the execute stage.

---
 rtl/alu_issue_stage.sv | 207 ++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue stage feeding the ALU.
// Decodes an RV32I instruction into an ALU control code plus operands A/B and
// registers them behind a two-entry (main + skid) buffer. The buffer keeps one
// instruction per cycle flowing while the execute side applies backpressure.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid / in_ready      upstream handshake (in_ready = skid buffer empty)
//   instr, pc                instruction word and its address
//   rs1_data, rs2_data       register-file read data
//   flush                    drop every buffered instruction (branch redirect)
//   out_valid / out_ready    execute-side handshake
//   Read_data1, Mux_Data     ALU operands A and B
//   ALU_Control              ALU operation code
//   rd_addr, rd_we           destination register and write-back enable
//   illegal                  instruction encoding not supported
module alu_issue_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   Read_data1,
  output logic [XLEN-1:0]   Mux_Data,
  output logic [CTRL_W-1:0] ALU_Control,
  output logic [4:0]        rd_addr,
  output logic              rd_we,
  output logic              illegal
);

  // Shared ALU control codes
  localparam logic [CTRL_W-1:0] AND_CTRL  = CTRL_W'(6'b000000);
  localparam logic [CTRL_W-1:0] OR_CTRL   = CTRL_W'(6'b000001);
  localparam logic [CTRL_W-1:0] ADD_CTRL  = CTRL_W'(6'b000010);
  localparam logic [CTRL_W-1:0] XOR_CTRL  = CTRL_W'(6'b000011);
  localparam logic [CTRL_W-1:0] SLL_CTRL  = CTRL_W'(6'b000100);
  localparam logic [CTRL_W-1:0] SRL_CTRL  = CTRL_W'(6'b000101);
  localparam logic [CTRL_W-1:0] SUB_CTRL  = CTRL_W'(6'b000110);
  localparam logic [CTRL_W-1:0] SLT_CTRL  = CTRL_W'(6'b000111);
  localparam logic [CTRL_W-1:0] SLTU_CTRL = CTRL_W'(6'b001000);
  localparam logic [CTRL_W-1:0] SRA_CTRL  = CTRL_W'(6'b001001);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rd;
    logic              we;
    logic              ill;
  } payload_t;

  // Base operation for a funct3 value (funct7-dependent variants resolved by caller)
  function automatic logic [CTRL_W-1:0] f3_ctrl(input logic [2:0] f3);
    case (f3)
      3'b000:  f3_ctrl = ADD_CTRL;
      3'b001:  f3_ctrl = SLL_CTRL;
      3'b010:  f3_ctrl = SLT_CTRL;
      3'b011:  f3_ctrl = SLTU_CTRL;
      3'b100:  f3_ctrl = XOR_CTRL;
      3'b101:  f3_ctrl = SRL_CTRL;
      3'b110:  f3_ctrl = OR_CTRL;
      default: f3_ctrl = AND_CTRL;
    endcase
  endfunction

  payload_t main_q, main_d, skid_q, skid_d, dec_c;
  logic     main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;

  logic [6:0]      opcode_c, f7_c;
  logic [2:0]      f3_c;
  logic [XLEN-1:0] imm_i_c, imm_s_c, imm_u_c, shamt_c;

  assign opcode_c = instr[6:0];
  assign f3_c     = instr[14:12];
  assign f7_c     = instr[31:25];
  assign imm_i_c  = XLEN'({{20{instr[31]}}, instr[31:20]});
  assign imm_s_c  = XLEN'({{20{instr[31]}}, instr[31:25], instr[11:7]});
  assign imm_u_c  = XLEN'({instr[31:12], 12'b0});
  assign shamt_c  = XLEN'({27'b0, instr[24:20]});

  // Instruction decode into the issue payload
  always_comb begin
    dec_c      = '0;
    dec_c.ctrl = ADD_CTRL;
    dec_c.rd   = instr[11:7];
    dec_c.a    = rs1_data;
    case (opcode_c)
      OP_R: begin
        dec_c.b    = rs2_data;
        dec_c.we   = 1'b1;
        dec_c.ctrl = f3_ctrl(f3_c);
        if (f7_c == F7_ALT && f3_c == 3'b000)      dec_c.ctrl = SUB_CTRL;
        else if (f7_c == F7_ALT && f3_c == 3'b101) dec_c.ctrl = SRA_CTRL;
        else if (f7_c != F7_ZERO)                  dec_c.ill  = 1'b1;
      end
      OP_I: begin
        dec_c.we   = 1'b1;
        dec_c.ctrl = f3_ctrl(f3_c);
        dec_c.b    = imm_i_c;
        if (f3_c == 3'b001) begin
          dec_c.b = shamt_c;
          if (f7_c != F7_ZERO) dec_c.ill = 1'b1;
        end else if (f3_c == 3'b101) begin
          dec_c.b = shamt_c;
          if (f7_c == F7_ALT)        dec_c.ctrl = SRA_CTRL;
          else if (f7_c != F7_ZERO)  dec_c.ill  = 1'b1;
        end
      end
      OP_LOAD: begin
        dec_c.b  = imm_i_c;
        dec_c.we = 1'b1;
      end
      OP_STORE: begin
        dec_c.b  = imm_s_c;
      end
      OP_LUI: begin
        dec_c.a  = '0;
        dec_c.b  = imm_u_c;
        dec_c.we = 1'b1;
      end
      OP_AUIPC: begin
        dec_c.a  = pc;
        dec_c.b  = imm_u_c;
        dec_c.we = 1'b1;
      end
      default: dec_c.ill = 1'b1;
    endcase
    // Unsupported encodings still flow through as inert add entries
    if (dec_c.ill) begin
      dec_c.a    = '0;
      dec_c.b    = '0;
      dec_c.ctrl = ADD_CTRL;
      dec_c.we   = 1'b0;
    end
    if (dec_c.rd == 5'd0) dec_c.we = 1'b0;
  end

  // Main/skid buffer next state; skid only fills while main is stalled
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_ready) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_valid) begin
        main_d       = dec_c;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_valid && !skid_valid_q) begin
      skid_d       = dec_c;
      skid_valid_d = 1'b1;
    end
  end

  // Buffer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready    = ~skid_valid_q;
  assign out_valid   = main_valid_q;
  assign Read_data1  = main_q.a;
  assign Mux_Data    = main_q.b;
  assign ALU_Control = main_q.ctrl;
  assign rd_addr     = main_q.rd;
  assign rd_we       = main_q.we;
  assign illegal     = main_q.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode table plus buffering/flush/reset sequences.
module tb_alu_issue_stage;

  localparam logic [5:0] AND_C  = 6'b000000;
  localparam logic [5:0] OR_C   = 6'b000001;
  localparam logic [5:0] ADD_C  = 6'b000010;
  localparam logic [5:0] XOR_C  = 6'b000011;
  localparam logic [5:0] SLL_C  = 6'b000100;
  localparam logic [5:0] SRL_C  = 6'b000101;
  localparam logic [5:0] SUB_C  = 6'b000110;
  localparam logic [5:0] SLT_C  = 6'b000111;
  localparam logic [5:0] SLTU_C = 6'b001000;
  localparam logic [5:0] SRA_C  = 6'b001001;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data, Read_data1, Mux_Data;
  logic [5:0]  ALU_Control;
  logic [4:0]  rd_addr;
  logic        rd_we, illegal;

  int checks = 0;
  int failures = 0;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .Read_data1(Read_data1), .Mux_Data(Mux_Data), .ALU_Control(ALU_Control),
    .rd_addr(rd_addr), .rd_we(rd_we), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic [31:0] a, b;
    logic [5:0]  ctrl;
    logic [4:0]  rd;
    logic        we, ill;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] ctrl, input logic [4:0] rd,
                         input logic we, input logic ill);
    chk({name, ".valid"}, 32'(out_valid), 32'd1);
    chk({name, ".A"},     Read_data1, a);
    chk({name, ".B"},     Mux_Data, b);
    chk({name, ".ctrl"},  32'(ALU_Control), 32'(ctrl));
    chk({name, ".rd"},    32'(rd_addr), 32'(rd));
    chk({name, ".we"},    32'(rd_we), 32'(we));
    chk({name, ".ill"},   32'(illegal), 32'(ill));
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1; instr = i; pc = p; rs1_data = r1; rs2_data = r2;
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({name, ".in_ready"},  32'(in_ready), 32'd1);
    chk({name, ".A"},         Read_data1, 32'd0);
    chk({name, ".B"},         Mux_Data, 32'd0);
    chk({name, ".ctrl"},      32'(ALU_Control), 32'd0);
    chk({name, ".rd_we"},     32'(rd_we), 32'd0);
    chk({name, ".illegal"},   32'(illegal), 32'd0);
  endtask

  initial begin
    //          instr         pc            rs1           rs2           A             B             ctrl    rd  we ill
    vecs[0]  = '{32'h00500093, 32'h0,        32'd7,        32'd0,        32'd7,        32'd5,        ADD_C,  1, 1, 0};
    vecs[1]  = '{32'h40208133, 32'h0,        32'd9,        32'd4,        32'd9,        32'd4,        SUB_C,  2, 1, 0};
    vecs[2]  = '{32'h4030D093, 32'h0,        32'h80000000, 32'd0,        32'h80000000, 32'd3,        SRA_C,  1, 1, 0};
    vecs[3]  = '{32'h00112223, 32'h0,        32'h100,      32'h55,       32'h100,      32'd4,        ADD_C,  4, 0, 0};
    vecs[4]  = '{32'h123452B7, 32'h0,        32'hABC,      32'd0,        32'd0,        32'h12345000, ADD_C,  5, 1, 0};
    vecs[5]  = '{32'h0000007F, 32'h0,        32'd1,        32'd2,        32'd0,        32'd0,        ADD_C,  0, 0, 1};
    vecs[6]  = '{32'hFFFFF197, 32'h1000,     32'd3,        32'd0,        32'h1000,     32'hFFFFF000, ADD_C,  3, 1, 0};
    vecs[7]  = '{32'hFFF00213, 32'h0,        32'h20,       32'd0,        32'h20,       32'hFFFFFFFF, ADD_C,  4, 1, 0};
    vecs[8]  = '{32'h0083B333, 32'h0,        32'd5,        32'd6,        32'd5,        32'd6,        SLTU_C, 6, 1, 0};
    vecs[9]  = '{32'h00208033, 32'h0,        32'd1,        32'd2,        32'd1,        32'd2,        ADD_C,  0, 0, 0};
    vecs[10] = '{32'h023100B3, 32'h0,        32'd7,        32'd8,        32'd0,        32'd0,        ADD_C,  1, 0, 1};
    vecs[11] = '{32'h40109093, 32'h0,        32'd7,        32'd8,        32'd0,        32'd0,        ADD_C,  1, 0, 1};
    vecs[12] = '{32'h00F14093, 32'h0,        32'hFF,       32'd0,        32'hFF,       32'hF,        XOR_C,  1, 1, 0};
    vecs[13] = '{32'h01F15093, 32'h0,        32'hF0,       32'd0,        32'hF0,       32'h1F,       SRL_C,  1, 1, 0};
    vecs[14] = '{32'hFFC0A283, 32'h0,        32'h40,       32'd0,        32'h40,       32'hFFFFFFFC, ADD_C,  5, 1, 0};
    vecs[15] = '{32'h403150B3, 32'h0,        32'd8,        32'h23,       32'd8,        32'h23,       SRA_C,  1, 1, 0};
    vecs[16] = '{32'h003170B3, 32'h0,        32'hC,        32'hA,        32'hC,        32'hA,        AND_C,  1, 1, 0};
    vecs[17] = '{32'h003120B3, 32'h0,        32'hC,        32'hA,        32'hC,        32'hA,        SLT_C,  1, 1, 0};

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state("reset");

    // Decode table: one instruction at a time, consumed immediately
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
      @(negedge clk);
      in_valid = 1'b0;
      chk_out($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ctrl,
              vecs[i].rd, vecs[i].we, vecs[i].ill);
    end
    @(negedge clk);
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Back-to-back issue at one per cycle with out_ready high
    drive(32'h00100093, 0, 0, 0);          // addi x1,x0,1
    @(negedge clk);
    chk_out("b2b0", 0, 1, ADD_C, 1, 1, 0);
    drive(32'h00200113, 0, 0, 0);          // addi x2,x0,2
    @(negedge clk);
    in_valid = 1'b0;
    chk_out("b2b1", 0, 2, ADD_C, 2, 1, 0);
    @(negedge clk);

    // Backpressure: three offered, two accepted, then in-order release
    out_ready = 1'b0;
    drive(32'h00100093, 0, 0, 0);          // B=1
    @(negedge clk);
    chk("bp.in_ready1", 32'(in_ready), 32'd1);
    drive(32'h00200093, 0, 0, 0);          // B=2
    @(negedge clk);
    chk("bp.in_ready_full", 32'(in_ready), 32'd0);
    drive(32'h00300093, 0, 0, 0);          // B=3, must wait
    @(negedge clk);
    chk("bp.in_ready_hold", 32'(in_ready), 32'd0);
    chk("bp.hold_B", Mux_Data, 32'd1);
    out_ready = 1'b1;
    chk_out("bp.out0", 0, 1, ADD_C, 1, 1, 0);
    @(negedge clk);
    chk_out("bp.out1", 0, 2, ADD_C, 1, 1, 0);
    chk("bp.in_ready_free", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk_out("bp.out2", 0, 3, ADD_C, 1, 1, 0);
    @(negedge clk);
    chk("bp.empty", 32'(out_valid), 32'd0);

    // Flush with both entries full and a new input offered
    out_ready = 1'b0;
    drive(32'h00100093, 0, 0, 0);
    @(negedge clk);
    drive(32'h00200093, 0, 0, 0);
    @(negedge clk);
    drive(32'h00900093, 0, 0, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    chk("flush.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("flush.not_issued", 32'(out_valid), 32'd0);

    // Reset mid-stream
    out_ready = 1'b0;
    drive(32'h4030D093, 0, 32'h55, 0);
    @(negedge clk);
    drive(32'h00F14093, 0, 32'h66, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst.valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    chk_reset_state("midrst");
    @(negedge clk);
    chk("midrst.stay_empty", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
